// File: rtl/rtc_alarm_ctrl.sv
// Wishbone-programmable RTC alarm comparator with confirm filtering,
// one-shot/periodic re-arming, sticky pending flag and saturating fire counter.
module rtc_alarm_ctrl #(
  parameter logic [15:0] PERIOD_RST     = 16'd0,
  parameter int unsigned CONFIRM_CYCLES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic [47:0] current_time,
  output logic        rtc_alarm
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CONFIRM = 2'd2
  } state_t;

  localparam logic [2:0] CONFIRM_LIMIT = 3'(CONFIRM_CYCLES);

  localparam logic [3:0] ADR_ALARM_2    = 4'd0;
  localparam logic [3:0] ADR_ALARM_1    = 4'd1;
  localparam logic [3:0] ADR_ALARM_0    = 4'd2;
  localparam logic [3:0] ADR_CTRL       = 4'd3;
  localparam logic [3:0] ADR_STATUS     = 4'd4;
  localparam logic [3:0] ADR_PERIOD     = 4'd5;
  localparam logic [3:0] ADR_FIRE_COUNT = 4'd6;

  logic        access;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  adr;
  logic        adr_unused;

  logic [15:0] alarm_buf2;
  logic [15:0] alarm_buf1;
  logic [15:0] alarm_buf0;
  logic [47:0] alarm;
  logic        ctrl_en;
  logic        ctrl_periodic;
  logic        ctrl_irq_en;
  logic [15:0] period;
  logic        pending;
  logic [15:0] fire_count;
  state_t      state;
  logic [2:0]  confirm_cnt;

  logic        wr_alarm2;
  logic        wr_alarm1;
  logic        wr_alarm0;
  logic        wr_ctrl;
  logic        wr_status;
  logic        wr_period;
  logic        wr_fire_count;
  logic        time_reached;
  logic        fire;
  logic        reload_en;
  logic        armed;
  logic [15:0] rdata;

  assign adr        = wb_adr_i[3:0];
  assign adr_unused = ^wb_adr_i[15:4];

  // A new access is accepted only while no ack is outstanding, giving ack every other cycle.
  assign access = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_en  = access & wb_we_i;
  assign rd_en  = access & ~wb_we_i;

  assign wr_alarm2     = wr_en & (adr == ADR_ALARM_2);
  assign wr_alarm1     = wr_en & (adr == ADR_ALARM_1);
  assign wr_alarm0     = wr_en & (adr == ADR_ALARM_0);
  assign wr_ctrl       = wr_en & (adr == ADR_CTRL);
  assign wr_status     = wr_en & (adr == ADR_STATUS);
  assign wr_period     = wr_en & (adr == ADR_PERIOD);
  assign wr_fire_count = wr_en & (adr == ADR_FIRE_COUNT);

  assign time_reached = (current_time >= alarm);
  assign fire         = (state == ST_CONFIRM) & time_reached &
                        ((confirm_cnt + 3'd1) >= CONFIRM_LIMIT);
  assign reload_en    = ctrl_periodic & (period != 16'd0);
  assign armed        = (state == ST_ARMED) | (state == ST_CONFIRM);
  assign rtc_alarm    = pending & ctrl_irq_en;

  // Register read mux; unmapped addresses return zero.
  always_comb begin
    rdata = 16'd0;
    case (adr)
      ADR_ALARM_2:    rdata = alarm_buf2;
      ADR_ALARM_1:    rdata = alarm_buf1;
      ADR_ALARM_0:    rdata = alarm_buf0;
      ADR_CTRL:       rdata = {13'd0, ctrl_irq_en, ctrl_periodic, ctrl_en};
      ADR_STATUS:     rdata = {14'd0, armed, pending};
      ADR_PERIOD:     rdata = period;
      ADR_FIRE_COUNT: rdata = fire_count;
      default:        rdata = 16'd0;
    endcase
  end

  // Wishbone handshake: registered ack and read data.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 16'd0;
    end else begin
      wb_ack_o <= access;
      wb_dat_o <= rd_en ? rdata : 16'd0;
    end
  end

  // Plain read/write configuration registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      alarm_buf2    <= 16'd0;
      alarm_buf1    <= 16'd0;
      alarm_buf0    <= 16'd0;
      ctrl_en       <= 1'b0;
      ctrl_periodic <= 1'b0;
      ctrl_irq_en   <= 1'b0;
      period        <= PERIOD_RST;
    end else begin
      if (wr_alarm2) alarm_buf2 <= wb_dat_i;
      if (wr_alarm1) alarm_buf1 <= wb_dat_i;
      if (wr_alarm0) alarm_buf0 <= wb_dat_i;
      if (wr_period) period     <= wb_dat_i;
      if (wr_ctrl) begin
        ctrl_en       <= wb_dat_i[0];
        ctrl_periodic <= wb_dat_i[1];
        ctrl_irq_en   <= wb_dat_i[2];
      end
    end
  end

  // Alarm FSM with pending flag and fire counter; register writes override the FSM step.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state       <= ST_IDLE;
      confirm_cnt <= 3'd0;
      alarm       <= 48'd0;
      pending     <= 1'b0;
      fire_count  <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          confirm_cnt <= 3'd0;
        end
        ST_ARMED: begin
          confirm_cnt <= 3'd0;
          if (time_reached) state <= ST_CONFIRM;
        end
        ST_CONFIRM: begin
          if (!time_reached) begin
            state       <= ST_ARMED;
            confirm_cnt <= 3'd0;
          end else if (fire) begin
            confirm_cnt <= 3'd0;
            if (reload_en) begin
              alarm <= alarm + {32'd0, period};
              state <= ST_ARMED;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            confirm_cnt <= confirm_cnt + 3'd1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          confirm_cnt <= 3'd0;
        end
      endcase

      // Set beats W1C clear when both land on the same edge.
      if (fire) begin
        pending <= 1'b1;
      end else if (wr_status && wb_dat_i[0]) begin
        pending <= 1'b0;
      end

      if (fire) begin
        if (wr_fire_count) begin
          fire_count <= 16'd1;
        end else if (fire_count != 16'hFFFF) begin
          fire_count <= fire_count + 16'd1;
        end
      end else if (wr_fire_count) begin
        fire_count <= 16'd0;
      end

      if (wr_ctrl) begin
        if (!wb_dat_i[0]) begin
          state       <= ST_IDLE;
          confirm_cnt <= 3'd0;
        end else if (!ctrl_en) begin
          state       <= ST_ARMED;
          confirm_cnt <= 3'd0;
        end
      end

      // A commit replaces any periodic reload computed on this edge.
      if (wr_alarm0) begin
        alarm <= {alarm_buf2, alarm_buf1, wb_dat_i};
        if (ctrl_en) begin
          state       <= ST_ARMED;
          confirm_cnt <= 3'd0;
        end
      end
    end
  end

endmodule
